// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and default sizes.
package stopwatch_pkg;

    // Encoding is visible on the debug LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } sw_state_e;

    localparam int unsigned MAX_COUNT_DEF   = 999999;
    localparam int unsigned CNT_W_DEF       = 20;
    localparam int unsigned DEBOUNCE_MS_DEF = 20;

    // RUN and LAP both advance the counter; LAP only freezes the display.
    function automatic logic is_counting(sw_state_e s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Counter/display side bus of the stopwatch controller.
// master: the controller; slave: the ms counter and display chain.
interface stopwatch_controller_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [CNT_W-1:0] ms_count;
    logic             count_en;
    logic             count_clr;
    logic [CNT_W-1:0] lap_value;
    logic [CNT_W-1:0] disp_value;
    logic [1:0]       state;

    modport master (
        input  ms_count,
        output count_en,
        output count_clr,
        output lap_value,
        output disp_value,
        output state
    );

    modport slave (
        output ms_count,
        input  count_en,
        input  count_clr,
        input  lap_value,
        input  disp_value,
        input  state
    );
endinterface

// File: rtl/key_conditioner.sv
// Conditions one raw active-low push-button into a single-cycle press event.
// Two-flop synchronizer, optional debounce filter (STOPWATCH_DEBOUNCE_EN), falling-edge detect.
// Without the filter a press sampled low at edge N raises the event after edge N+2.
module key_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_MS = 20
)
`endif
(
    input  logic clk,
    input  logic reset,
`ifdef STOPWATCH_DEBOUNCE_EN
    input  logic tick_ms,
`endif
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_prev;
    logic press_q;

    // Two-flop synchronizer; loads the released level on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned DbW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    logic [DbW-1:0] db_cnt;
    logic           level_q;

    // Filtered level follows the synchronized key only after DEBOUNCE_MS
    // consecutive ticks at the new level; any return to the old level restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt  <= '0;
            level_q <= 1'b1;
        end else if (sync2 == level_q) begin
            db_cnt <= '0;
        end else if (tick_ms) begin
            if (db_cnt == DbW'(DEBOUNCE_MS - 1)) begin
                level_q <= sync2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

    // Registered falling-edge detect: one event per press, none on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            level_prev <= level;
            press_q    <= level_prev & ~level;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: turns start/stop/lap key presses into counter commands
// (count enable, clear, lap capture) and selects live or frozen value for display.
// Optional key debounce filter is enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_COUNT   = MAX_COUNT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick_ms,
    input  logic                   start_n,
    input  logic                   stop_n,
    input  logic                   lap_n,
    stopwatch_controller_if.master bus
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_COUNT);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_MS == 0) begin : g_bad_debounce
        $error("DEBOUNCE_MS must be at least 1");
    end
    if ((CNT_W < 32) && (MAX_COUNT >= (32'd1 << CNT_W))) begin : g_bad_max
        $error("MAX_COUNT does not fit in CNT_W bits");
    end

    logic ev_start;
    logic ev_stop;
    logic ev_lap;

    key_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
    #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    )
`endif
    u_start (
        .clk    (clk),
        .reset  (reset),
`ifdef STOPWATCH_DEBOUNCE_EN
        .tick_ms(tick_ms),
`endif
        .key_n  (start_n),
        .press  (ev_start)
    );

    key_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
    #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    )
`endif
    u_stop (
        .clk    (clk),
        .reset  (reset),
`ifdef STOPWATCH_DEBOUNCE_EN
        .tick_ms(tick_ms),
`endif
        .key_n  (stop_n),
        .press  (ev_stop)
    );

    key_conditioner
`ifdef STOPWATCH_DEBOUNCE_EN
    #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    )
`endif
    u_lap (
        .clk    (clk),
        .reset  (reset),
`ifdef STOPWATCH_DEBOUNCE_EN
        .tick_ms(tick_ms),
`endif
        .key_n  (lap_n),
        .press  (ev_lap)
    );

    sw_state_e        state_q;
    logic             clr_q;
    logic [CNT_W-1:0] lap_q;
    logic [CNT_W-1:0] disp_q;

    logic counting;
    logic below_max;
    logic terminal;

    // Counter qualification; terminal count turns a tick into a stop instead.
    always_comb begin
        counting  = is_counting(state_q);
        below_max = (bus.ms_count < MaxVal);
        terminal  = tick_ms & counting & ~below_max;
    end

    // FSM with registered clear strobe, lap register and display mux.
    // Event priority: terminal count, then stop > start > lap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
            lap_q   <= '0;
            disp_q  <= '0;
        end else begin
            clr_q  <= 1'b0;
            disp_q <= (state_q == LAP) ? lap_q : bus.ms_count;
            if (terminal) begin
                state_q <= STOP;
            end else if (ev_stop) begin
                if (counting) begin
                    state_q <= STOP;
                end
            end else if (ev_start) begin
                // From IDLE starts, from STOP resumes without clearing, from LAP unfreezes.
                state_q <= RUN;
            end else if (ev_lap) begin
                case (state_q)
                    RUN, LAP: begin
                        state_q <= LAP;
                        lap_q   <= bus.ms_count;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        clr_q   <= 1'b1;
                        lap_q   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs: clear only ever asserts in IDLE, so it cannot overlap count_en.
    always_comb begin
        bus.count_en   = tick_ms & counting & below_max;
        bus.count_clr  = clr_q;
        bus.lap_value  = lap_q;
        bus.disp_value = disp_q;
        bus.state      = state_q;
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed vector table, corner-case sequences and
// randomized keys/ticks checked against a key-history based reference model.
module tb_stopwatch_controller;

    localparam int MAXC = 999999;

    logic clk = 1'b0;
    logic reset   = 1'b0;
    logic tick_ms = 1'b0;
    logic start_n = 1'b1;
    logic stop_n  = 1'b1;
    logic lap_n   = 1'b1;

    stopwatch_controller_if #(.CNT_W(20)) bus ();

    stopwatch_controller dut (
        .clk    (clk),
        .reset  (reset),
        .tick_ms(tick_ms),
        .start_n(start_n),
        .stop_n (stop_n),
        .lap_n  (lap_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt    = 0;

    int s_state, s_en, s_clr, s_lap, s_disp, s_cnt;

    // Reference model state
    bit model_on = 1'b0;
    bit m_valid  = 1'b0;
    int m_state, m_clr, m_lap, m_disp;
    bit hs[5], hp[5], hl[5];

    typedef struct {
        bit rst, tick, s_n, p_n, l_n;
        int frc;
        bit chk;
        int st, en, clr, lap, disp, cn;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_en();
        return (tick_ms && (m_state == 1 || m_state == 3) && cnt < MAXC) ? 1 : 0;
    endfunction

    // Event reaches the FSM three edges after the first low sample: at the current
    // edge the window holds samples of edges k-4..k, oldest first.
    task automatic model_step();
        bit ev_s, ev_p, ev_l, running;
        int nd;
        if (reset) begin
            m_valid = 1'b1;
            m_state = 0; m_clr = 1; m_lap = 0; m_disp = 0;
            for (int i = 0; i < 5; i++) begin
                hs[i] = 1'b1; hp[i] = 1'b1; hl[i] = 1'b1;
            end
            return;
        end
        for (int i = 0; i < 4; i++) begin
            hs[i] = hs[i+1]; hp[i] = hp[i+1]; hl[i] = hl[i+1];
        end
        hs[4] = start_n; hp[4] = stop_n; hl[4] = lap_n;
        ev_s = hs[0] && !hs[1];
        ev_p = hp[0] && !hp[1];
        ev_l = hl[0] && !hl[1];
        running = (m_state == 1 || m_state == 3);
        nd = (m_state == 3) ? m_lap : cnt;
        m_clr = 0;
        if (running && tick_ms && cnt >= MAXC) m_state = 2;
        else if (ev_p) begin
            if (running) m_state = 2;
        end else if (ev_s) m_state = 1;
        else if (ev_l) begin
            if (running) begin
                m_state = 3; m_lap = cnt;
            end else if (m_state == 2) begin
                m_state = 0; m_clr = 1; m_lap = 0;
            end
        end
        m_disp = nd;
    endtask

    // One clock: drive ms_count, sample at negedge, advance model and counter datapath.
    task automatic cyc();
        bus.ms_count = 20'(cnt);
        @(negedge clk);
        s_state = int'(bus.state);
        s_en    = int'(bus.count_en);
        s_clr   = int'(bus.count_clr);
        s_lap   = int'(bus.lap_value);
        s_disp  = int'(bus.disp_value);
        s_cnt   = int'(bus.ms_count);
        if (model_on && m_valid) begin
            check("model_state", s_state, m_state);
            check("model_count_en", s_en, model_en());
            check("model_count_clr", s_clr, m_clr);
            check("model_lap_value", s_lap, m_lap);
            check("model_disp_value", s_disp, m_disp);
            if (s_en == 1 && s_clr == 1) check("en_clr_overlap", 1, 0);
        end
        @(posedge clk);
        #1;
        model_step();
        if (reset) cnt = 0;
        else if (s_clr == 1) cnt = 0;
        else if (s_en == 1) cnt++;
    endtask

    task automatic press(input int which);
        if (which == 0) start_n = 1'b0;
        else if (which == 1) stop_n = 1'b0;
        else lap_n = 1'b0;
        cyc();
        start_n = 1'b1; stop_n = 1'b1; lap_n = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic add(input bit rst, input bit tick, input bit s_n, input bit p_n, input bit l_n,
                       input int frc, input bit chk, input int st, input int en, input int clr,
                       input int lap, input int disp, input int cn);
        vec_t v;
        v.rst = rst; v.tick = tick; v.s_n = s_n; v.p_n = p_n; v.l_n = l_n; v.frc = frc;
        v.chk = chk; v.st = st; v.en = en; v.clr = clr; v.lap = lap; v.disp = disp; v.cn = cn;
        vecs.push_back(v);
    endtask

    initial begin
`ifndef STOPWATCH_DEBOUNCE_EN
        model_on = 1'b1;
        // rst tick s p l frc | chk st en clr lap disp cnt   (-1: don't care)
        add(1, 0, 1, 1, 1, -1,  0, 0, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 0, 0, 1, 0, 0, 0);       // reset state, clear strobe
        add(0, 0, 0, 1, 1, -1,  1, 0, 0, 0, 0, 0, 0);       // start sampled low
        add(0, 0, 1, 1, 1, -1,  1, 0, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 0, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 0, 0, 0, -1, -1, -1);
        add(0, 1, 1, 1, 1, -1,  1, 1, 1, 0, -1, -1, 0);     // RUN three edges later
        add(0, 1, 1, 1, 1, -1,  1, 1, 1, 0, -1, -1, 1);
        add(0, 1, 1, 1, 1, -1,  1, 1, 1, 0, -1, -1, 2);
        add(0, 1, 1, 1, 1, -1,  1, 1, 1, 0, -1, -1, 3);
        add(0, 1, 1, 1, 1, -1,  1, 1, 1, 0, -1, -1, 4);
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, 5);     // exactly five increments
        add(0, 0, 1, 1, 0, 1234, 1, 1, 0, 0, -1, -1, 1234); // lap at 1234
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, -1);
        add(0, 1, 1, 1, 1, -1,  1, 3, 1, 0, 1234, 1234, 1234);
        add(0, 1, 1, 1, 1, -1,  1, 3, 1, 0, 1234, 1234, 1235); // display frozen, still counting
        add(0, 0, 0, 1, 1, -1,  1, 3, 0, 0, 1234, 1234, 1236);
        add(0, 0, 1, 1, 1, -1,  1, 3, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 3, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 3, 0, 0, -1, -1, -1);
        add(0, 1, 0, 0, 1, -1,  1, 1, 1, 0, -1, -1, 1236); // start+stop together
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, 1237);
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, -1);
        add(0, 0, 1, 1, 1, -1,  1, 1, 0, 0, -1, -1, -1);
        add(0, 1, 1, 1, 1, -1,  1, 2, 0, 0, -1, -1, 1237); // stop wins
        add(0, 1, 1, 1, 1, -1,  1, 2, 0, 0, -1, -1, 1237);
        add(0, 0, 1, 1, 1, -1,  1, 2, 0, 0, 1234, 1237, 1237);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; tick_ms = vecs[i].tick;
            start_n = vecs[i].s_n; stop_n = vecs[i].p_n; lap_n = vecs[i].l_n;
            if (vecs[i].frc >= 0) cnt = vecs[i].frc;
            cyc();
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_state", i), s_state, vecs[i].st);
                check($sformatf("vec%0d_count_en", i), s_en, vecs[i].en);
                check($sformatf("vec%0d_count_clr", i), s_clr, vecs[i].clr);
                if (vecs[i].lap >= 0) check($sformatf("vec%0d_lap", i), s_lap, vecs[i].lap);
                if (vecs[i].disp >= 0) check($sformatf("vec%0d_disp", i), s_disp, vecs[i].disp);
                if (vecs[i].cn >= 0) check($sformatf("vec%0d_ms_count", i), s_cnt, vecs[i].cn);
            end
        end
        reset = 1'b0; tick_ms = 1'b0; start_n = 1'b1; stop_n = 1'b1; lap_n = 1'b1;

        // Resume from STOP keeps the count
        press(0); cyc();
        check("resume_state", s_state, 1);
        check("resume_no_clear", s_cnt, 1237);
        // Terminal count
        cnt = MAXC; tick_ms = 1'b1; cyc();
        check("terminal_no_en", s_en, 0);
        tick_ms = 1'b0; cyc();
        check("terminal_to_stop", s_state, 2);
        check("terminal_no_wrap", s_cnt, MAXC);
        // Lap in STOP clears back to IDLE
        press(2); cyc();
        check("stop_lap_idle", s_state, 0);
        check("stop_lap_clr", s_clr, 1);
        check("stop_lap_zero", s_lap, 0);
        cyc();
        check("clr_one_cycle", s_clr, 0);
        check("cleared_count", s_cnt, 0);
        press(1); cyc();
        check("idle_ignores_stop", s_state, 0);
        // Reset with a pending event drops it
        press(0); cyc();
        check("run_again", s_state, 1);
        stop_n = 1'b0; cyc();
        stop_n = 1'b1; cyc();
        reset = 1'b1; cyc();
        reset = 1'b0; tick_ms = 1'b1; cyc();
        check("reset_idle", s_state, 0);
        check("reset_clr", s_clr, 1);
        check("reset_no_en", s_en, 0);
        start_n = 1'b1; repeat (3) cyc();
        check("pending_dropped", s_state, 0);
        check("reset_clr_done", s_clr, 0);
        tick_ms = 1'b0;

        // Randomized keys, ticks, resets and near-terminal counts
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            tick_ms = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) start_n = ~start_n;
            if ($urandom_range(0, 9) == 0) stop_n  = ~stop_n;
            if ($urandom_range(0, 7) == 0) lap_n   = ~lap_n;
            if ($urandom_range(0, 149) == 0) cnt = MAXC - int'($urandom_range(0, 3));
            cyc();
        end
`else
        // Debounced build: a short bounce is rejected, a long hold starts the watch
        reset = 1'b1; cyc();
        reset = 1'b0; tick_ms = 1'b1; cyc();
        check("db_reset_state", s_state, 0);
        check("db_reset_clr", s_clr, 1);
        start_n = 1'b0; repeat (3) cyc();
        start_n = 1'b1; repeat (40) cyc();
        check("db_bounce_rejected", s_state, 0);
        start_n = 1'b0; repeat (15) cyc();
        check("db_too_early", s_state, 0);
        repeat (20) cyc();
        check("db_held_starts", s_state, 1);
        check("db_counting", s_en, 1);
        start_n = 1'b1; repeat (40) cyc();
        check("db_release_no_event", s_state, 1);
        stop_n = 1'b0; repeat (30) cyc();
        check("db_stop", s_state, 2);
        stop_n = 1'b1; lap_n = 1'b0; repeat (30) cyc();
        check("db_lap_idle", s_state, 0);
        check("db_lap_zero", s_lap, 0);
        lap_n = 1'b1; tick_ms = 1'b0; cyc();
        check("db_idle_no_en", s_en, 0);
        check("db_idle_no_clr", s_clr, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
